// File: rtl/sift_key_if.sv
// -----------------------------------------------------------------------------
// sift_key_ctrl_if
// Bundles the control handshake and sifting datapath signals of sift_key_ctrl.
//   master : drives start, abort, sifted_valid, sifted_sender, key_ack and
//            observes busy, key_out, key_valid, key_fail, bit_count, scan_idx
//   slave  : the controller side (mirror image of master)
// -----------------------------------------------------------------------------
interface sift_key_ctrl_if #(
    parameter int N_POS    = 640,
    parameter int KEY_BITS = 128
);
    logic                start;
    logic                abort;
    logic [N_POS-1:0]    sifted_valid;
    logic [N_POS-1:0]    sifted_sender;
    logic                key_ack;
    logic                busy;
    logic [KEY_BITS-1:0] key_out;
    logic                key_valid;
    logic                key_fail;
    logic [7:0]          bit_count;
    logic [9:0]          scan_idx;

    modport master (
        output start, abort, sifted_valid, sifted_sender, key_ack,
        input  busy, key_out, key_valid, key_fail, bit_count, scan_idx
    );

    modport slave (
        input  start, abort, sifted_valid, sifted_sender, key_ack,
        output busy, key_out, key_valid, key_fail, bit_count, scan_idx
    );
endinterface

// File: rtl/sift_key_ctrl.sv
// -----------------------------------------------------------------------------
// sift_key_ctrl
// Scans N_POS basis-match flags in ascending order and compacts the sender bits
// of the matching positions into a KEY_BITS-wide key. Reports DONE when the key
// is full, FAIL when the positions run out first.
// Ports:
//   clk    : sole clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : sift_key_ctrl_if.slave
//            in  start, abort, sifted_valid, sifted_sender, key_ack
//            out busy, key_out, key_valid, key_fail, bit_count, scan_idx
// -----------------------------------------------------------------------------
module sift_key_ctrl #(
    parameter int N_POS    = 640,
    parameter int KEY_BITS = 128
) (
    input  logic            clk,
    input  logic            rst_n,
    sift_key_ctrl_if.slave  bus
);
    localparam int         IW        = $clog2(N_POS);
    localparam int         KW        = $clog2(KEY_BITS);
    localparam logic [7:0] KEY_LIMIT = 8'(KEY_BITS);
    localparam logic [9:0] LAST_IDX  = 10'(N_POS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_SIFT,
        S_SCAN,
        S_DONE,
        S_FAIL
    } state_t;

    state_t              r_state;
    logic                r_busy;
    logic                r_key_valid;
    logic                r_key_fail;
    logic [KEY_BITS-1:0] r_key_out;
    logic [7:0]          r_bit_count;
    logic [9:0]          r_scan_idx;

    logic                w_hit;
    logic                w_sender_bit;
    logic [7:0]          w_next_count;

    assign w_hit        = bus.sifted_valid[r_scan_idx[IW-1:0]];
    assign w_sender_bit = bus.sifted_sender[r_scan_idx[IW-1:0]];
    assign w_next_count = r_bit_count + 8'd1;

    // NOTE: every register here is written with <= so all reads within the
    // block see the pre-edge values; the key register is a plain flop vector,
    // so it is reset along with the rest of the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_key_valid <= 1'b0;
            r_key_fail  <= 1'b0;
            r_key_out   <= '0;
            r_bit_count <= '0;
            r_scan_idx  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state     <= S_WAIT_SIFT;
                        r_busy      <= 1'b1;
                        r_key_out   <= '0;
                        r_bit_count <= '0;
                        r_scan_idx  <= '0;
                    end
                end

                // Absorbs the one-register latency of the sifting datapath.
                S_WAIT_SIFT: begin
                    if (bus.abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= S_SCAN;
                    end
                end

                S_SCAN: begin
                    if (bus.abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        if (w_hit) begin
                            r_key_out[r_bit_count[KW-1:0]] <= w_sender_bit;
                            r_bit_count                    <= w_next_count;
                        end
                        // A completing write wins over running out of
                        // positions; scan_idx is left on the last position
                        // examined when the scan ends.
                        if (w_hit && (w_next_count == KEY_LIMIT)) begin
                            r_state     <= S_DONE;
                            r_key_valid <= 1'b1;
                        end else if (r_scan_idx == LAST_IDX) begin
                            r_state    <= S_FAIL;
                            r_key_fail <= 1'b1;
                        end else begin
                            r_scan_idx <= r_scan_idx + 10'd1;
                        end
                    end
                end

                S_DONE: begin
                    if (bus.key_ack) begin
                        r_state     <= S_IDLE;
                        r_busy      <= 1'b0;
                        r_key_valid <= 1'b0;
                    end
                end

                S_FAIL: begin
                    if (bus.key_ack) begin
                        r_state    <= S_IDLE;
                        r_busy     <= 1'b0;
                        r_key_fail <= 1'b0;
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_busy      <= 1'b0;
                    r_key_valid <= 1'b0;
                    r_key_fail  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.key_out   = r_key_out;
    assign bus.key_valid = r_key_valid;
    assign bus.key_fail  = r_key_fail;
    assign bus.bit_count = r_bit_count;
    assign bus.scan_idx  = r_scan_idx;
endmodule

// File: tb/tb_sift_key_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sift_key_ctrl
// Self-checking bench for sift_key_ctrl: a table of sifting patterns with
// expected results pushed to a scoreboard queue at start and popped when the
// controller reports key_valid/key_fail, plus hand-written abort, reset and
// hold sequences.
// -----------------------------------------------------------------------------
module tb_sift_key_ctrl;
    localparam int N = 640;
    localparam int K = 128;
    localparam int NV = 6;

    typedef struct {
        bit               done;
        logic [K-1:0]     key;
        int               count;
        int               idx;
        int               edges;
    } exp_t;

    typedef struct {
        string            name;
        logic [N-1:0]     valid;
        logic [N-1:0]     sender;
        exp_t             exp;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    vec_t vecs [NV];
    exp_t sb_q [$];

    sift_key_ctrl_if #(.N_POS(N), .KEY_BITS(K)) bus ();

    sift_key_ctrl #(.N_POS(N), .KEY_BITS(K)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [K-1:0] act, input logic [K-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: walk positions in order, collect sender bits of matches.
    function automatic exp_t model(input logic [N-1:0] v, input logic [N-1:0] s);
        exp_t e;
        e.done = 1'b0; e.key = '0; e.count = 0; e.idx = N - 1; e.edges = N + 1;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                e.key[e.count] = s[i];
                e.count++;
                if (e.count == K) begin
                    e.done  = 1'b1;
                    e.idx   = i;
                    e.edges = i + 2;
                    return e;
                end
            end
        end
        return e;
    endfunction

    task automatic wait_idx(input int target, input string name);
        int n;
        n = 0;
        while (bus.scan_idx !== 10'(target) && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) check({name, "_timeout"}, 128'(bus.scan_idx), 128'(target));
    endtask

    task automatic run_vector(input int v);
        exp_t   e;
        int     edges;
        bit     got;
        bit     stable;
        logic [K-1:0] held_key;
        string  nm;
        nm = vecs[v].name;
        bus.sifted_valid  = vecs[v].valid;
        bus.sifted_sender = vecs[v].sender;
        bus.start = 1'b1;
        tick();                                   // E0
        bus.start = 1'b0;
        sb_q.push_back(vecs[v].exp);
        check({nm, "_busy_after_start"}, 128'(bus.busy), 128'(1));
        edges = 0;
        got   = 1'b0;
        while (!got && edges < 800) begin
            tick();
            edges++;
            if (bus.key_valid === 1'b1 || bus.key_fail === 1'b1) got = 1'b1;
        end
        e = sb_q.pop_front();
        if (!got) begin
            check({nm, "_timeout"}, 128'(0), 128'(1));
            return;
        end
        check({nm, "_edges"},     128'(edges),          128'(e.edges));
        check({nm, "_key_valid"}, 128'(bus.key_valid),  128'(e.done));
        check({nm, "_key_fail"},  128'(bus.key_fail),   128'(!e.done));
        check({nm, "_key_out"},   bus.key_out,          e.key);
        check({nm, "_bit_count"}, 128'(bus.bit_count),  128'(e.count));
        check({nm, "_scan_idx"},  128'(bus.scan_idx),   128'(e.idx));

        // Hold without ack for 20 cycles; abort in the first one must be ignored.
        stable   = 1'b1;
        held_key = bus.key_out;
        bus.abort = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            bus.abort = 1'b0;
            if (bus.key_valid !== e.done || bus.key_fail !== !e.done ||
                bus.key_out !== held_key || bus.busy !== 1'b1) stable = 1'b0;
        end
        check({nm, "_hold_stable"}, 128'(stable), 128'(1));

        bus.key_ack = 1'b1;
        tick();
        bus.key_ack = 1'b0;
        check({nm, "_idle_after_ack"},
              128'({bus.busy, bus.key_valid, bus.key_fail}), 128'(0));
        check({nm, "_key_retained"}, bus.key_out, e.key);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        bus.start = 1'b0; bus.abort = 1'b0; bus.key_ack = 1'b0;
        bus.sifted_valid = '0; bus.sifted_sender = '0;

        // ---- vector table ----
        // 0: all valid, sender 1010... (position 0 = 1)
        vecs[0].name = "alt_all_valid";
        vecs[0].valid = '1;
        for (int i = 0; i < N; i++) vecs[0].sender[i] = (i % 2 == 0);
        vecs[0].exp = '{done: 1'b1, key: {32{4'h5}}, count: 128, idx: 127, edges: 129};

        // 1: even positions valid only, odd sender bits undefined
        vecs[1].name = "even_only";
        vecs[1].exp = '{done: 1'b1, key: '0, count: 128, idx: 254, edges: 256};
        for (int i = 0; i < N; i++) begin
            vecs[1].valid[i]  = (i % 2 == 0);
            vecs[1].sender[i] = (i % 2 == 0) ? 1'($urandom_range(0, 1)) : 1'bx;
        end
        for (int j = 0; j < K; j++) vecs[1].exp.key[j] = vecs[1].sender[2 * j];

        // 2: exactly 127 matches (5,10,...,635)
        vecs[2].name = "only_127";
        vecs[2].exp = '{done: 1'b0, key: '0, count: 127, idx: 639, edges: 641};
        for (int i = 0; i < N; i++) begin
            vecs[2].valid[i]  = (i % 5 == 0) && (i != 0);
            vecs[2].sender[i] = 1'($urandom_range(0, 1));
        end
        for (int j = 0; j < 127; j++) vecs[2].exp.key[j] = vecs[2].sender[5 * (j + 1)];

        // 3: exactly 128 matches (4,9,...,639), last one completes the key
        vecs[3].name = "last_at_639";
        vecs[3].exp = '{done: 1'b1, key: '0, count: 128, idx: 639, edges: 641};
        for (int i = 0; i < N; i++) begin
            vecs[3].valid[i]  = (i % 5 == 4);
            vecs[3].sender[i] = 1'($urandom_range(0, 1));
        end
        for (int j = 0; j < K; j++) vecs[3].exp.key[j] = vecs[3].sender[5 * j + 4];

        // 4: random density ~25%
        vecs[4].name = "random_sparse";
        for (int i = 0; i < N; i++) begin
            vecs[4].valid[i]  = ($urandom_range(0, 3) == 0);
            vecs[4].sender[i] = 1'($urandom_range(0, 1));
        end
        vecs[4].exp = model(vecs[4].valid, vecs[4].sender);

        // 5: random density ~50%
        vecs[5].name = "random_dense";
        for (int i = 0; i < N; i++) begin
            vecs[5].valid[i]  = 1'($urandom_range(0, 1));
            vecs[5].sender[i] = 1'($urandom_range(0, 1));
        end
        vecs[5].exp = model(vecs[5].valid, vecs[5].sender);

        // ---- reset state ----
        repeat (3) tick();
        check("reset_outputs",
              128'({bus.busy, bus.key_valid, bus.key_fail, bus.bit_count, bus.scan_idx}), 128'(0));
        check("reset_key_out", bus.key_out, '0);
        rst_n = 1'b1;
        bus.key_ack = 1'b1;                       // ack in IDLE is ignored
        tick();
        bus.key_ack = 1'b0;
        check("ack_in_idle", 128'(bus.busy), 128'(0));

        for (int v = 0; v < NV; v++) run_vector(v);

        // ---- abort in WAIT_SIFT ----
        bus.sifted_valid = '0;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        bus.abort = 1'b1; tick(); bus.abort = 1'b0;
        check("abort_wait_sift",
              128'({bus.busy, bus.key_valid, bus.key_fail}), 128'(0));

        // ---- abort at scan_idx 50 ----
        for (int i = 0; i < N; i++) bus.sifted_valid[i] = (i < 20);
        bus.sifted_sender = '1;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        wait_idx(50, "abort_wait");
        bus.abort = 1'b1; tick(); bus.abort = 1'b0;
        check("abort_scan", 128'({bus.busy, bus.key_valid, bus.key_fail}), 128'(0));
        repeat (3) tick();
        check("abort_stays_idle", 128'({bus.busy, bus.key_valid, bus.key_fail}), 128'(0));

        // ---- start/ack while busy ignored, then reset mid-scan ----
        for (int i = 0; i < N; i++) bus.sifted_valid[i] = (i < 40);
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        wait_idx(100, "busy_wait");
        bus.start = 1'b1; bus.key_ack = 1'b1;
        tick();
        bus.start = 1'b0; bus.key_ack = 1'b0;
        check("start_ignored_idx",   128'(bus.scan_idx),  128'(101));
        check("start_ignored_count", 128'(bus.bit_count), 128'(40));
        check("start_ignored_busy",  128'(bus.busy),      128'(1));
        wait_idx(300, "reset_wait");
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_flags",
              128'({bus.busy, bus.key_valid, bus.key_fail}), 128'(0));
        check("async_reset_count", 128'(bus.bit_count), 128'(0));
        check("async_reset_idx",   128'(bus.scan_idx),  128'(0));
        check("async_reset_key",   bus.key_out,         '0);
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check("no_run_after_reset", 128'({bus.busy, bus.scan_idx}), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/sift_key_ctrl.md
SIFT_KEY_CTRL -- requirements
Module: sift_key_ctrl

Interface
REQ-001 Parameter N_POS, default 640, number of qubit positions scanned per run.
REQ-002 Parameter KEY_BITS, default 128, number of sifted bits making one key.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request one sifting run; sampled only in IDLE.
REQ-006 abort  input  1  synchronous cancel of a run in progress.
REQ-007 sifted_valid  input  N_POS  per-position basis-match flag from the sifting datapath.
REQ-008 sifted_sender  input  N_POS  per-position sifted bit from the sifting datapath.
REQ-009 key_ack  input  1  consumer acknowledge of key_valid or key_fail.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 key_out  output  KEY_BITS  compacted key; bit j is the j-th valid position found.
REQ-012 key_valid  output  1  high in DONE.
REQ-013 key_fail  output  1  high in FAIL: fewer than KEY_BITS matches in N_POS positions.
REQ-014 bit_count  output  8  sifted bits collected so far this run.
REQ-015 scan_idx  output  10  position currently being examined.

Function
REQ-016 States: IDLE, WAIT_SIFT, SCAN, DONE, FAIL; all outputs registered.
REQ-017 IDLE, start=1: -> WAIT_SIFT; clear bit_count, scan_idx, key_out.
REQ-018 WAIT_SIFT: one cycle only, covering the sifting datapath's one-register latency; -> SCAN unconditionally.
REQ-019 SCAN: one position per clock, index = scan_idx, ascending from 0.
REQ-020 SCAN, sifted_valid[idx]=1: key_out[bit_count] <= sifted_sender[idx]; bit_count increments.
REQ-021 SCAN, sifted_valid[idx]=0: sifted_sender[idx] ignored (may be X); no key write; bit_count unchanged.
REQ-022 SCAN: scan_idx increments every cycle; it does not wrap.
REQ-023 SCAN: when a write makes bit_count = KEY_BITS -> DONE; remaining positions not scanned.
REQ-024 SCAN: at idx = N_POS-1 with bit_count still < KEY_BITS after that cycle's update -> FAIL.
REQ-025 Simultaneous: idx = N_POS-1 and its write completes KEY_BITS -> DONE, not FAIL.
REQ-026 Latency: start sampled at edge E0; SCAN entered at E1; position k processed at E(k+2); with all positions valid, key_valid rises after E(KEY_BITS+1) = E129.
REQ-027 DONE: key_valid and key_out held stable until key_ack=1, then -> IDLE; key_out retains its value in IDLE.
REQ-028 FAIL: key_fail held until key_ack=1, then -> IDLE; key_out holds the partial key.
REQ-029 key_ack outside DONE/FAIL is ignored; start outside IDLE is ignored.
REQ-030 abort=1 in WAIT_SIFT or SCAN -> IDLE next edge; key_valid and key_fail stay 0; abort has priority over REQ-023/024.
REQ-031 abort in DONE/FAIL is ignored; only key_ack leaves those states.
REQ-032 Inputs sifted_valid and sifted_sender are held stable by the system from start until exit from SCAN; the block does not latch them.

Reset
REQ-033 rst_n=0 immediately forces IDLE; busy, key_valid, key_fail = 0; key_out, bit_count, scan_idx = 0; this applies in any state, including mid-SCAN.
REQ-034 After rst_n deasserts, the first run requires a new start.

Verification
REQ-035 All 640 valid, sifted_sender alternating 1010...; pulse start -> key_valid high after E129, key_out = 128 bits matching positions 0..127, bit_count=128, scan_idx stops at 127.
REQ-036 Only even positions valid -> DONE after position 254 is processed; key_out[j] = sifted_sender[2j].
REQ-037 Exactly 127 valid positions -> key_fail after position 639 is processed (edge E641); bit_count=127; key_ack -> IDLE next cycle.
REQ-038 Exactly 128 valid, the last at position 639 -> DONE, not FAIL; key_out[127] = sifted_sender[639].
REQ-039 abort at scan_idx=50 -> IDLE next edge with busy=0, no key_valid; also hold key_ack low for 20 cycles in DONE -> key_valid and key_out stable throughout.
REQ-040 rst_n low at scan_idx=300 -> all outputs 0 immediately, with no clock edge required; start while busy is ignored.
